cam_emu_tx: RTL and testbench
=============================

# cam_emu_tx

Camera-side transmitter for the OV7670-style parallel pixel bus: generates pclk, vsync, href and 8-bit RGB565 byte pairs from synthetic test patterns. It drives the same bus the camera-capture receiver consumes, so capture, dual-port buffer and VGA path can be exercised on the board or in simulation without a sensor. It sits in place of the camera pins and is fed by the 24 MHz camera clock.

## Interface

Parameters:
- H_ACTIVE, 160, active pixels per line (2 bytes each)
- V_ACTIVE, 120, active lines per frame
- H_BLANK, 144, href-low pclk periods after each active line
- VSYNC_LINES, 3, lines with vsync high
- V_BACK, 17, blank lines after vsync
- V_FRONT, 10, blank lines after the last active line

Ports:
- clk  in  1  generator clock (24 MHz)
- rst  in  1  asynchronous reset, active-low
- run  in  1  level; frames are generated while high
- pat_sel  in  2  pattern select: 0 colour bars, 1 gradient, 2 pixel counter, 3 solid
- solid_rgb565  in  16  colour for pattern 3
- pclk  out  1  pixel clock, clk/2
- vsync  out  1  frame sync, active high
- href  out  1  line valid, active high
- px_data  out  8  pixel byte
- frame_done  out  1  one-clk pulse at end of each frame
- frame_cnt  out  16  completed frames, wraps at 0xFFFF
- checksum  out  16  byte sum of last completed frame (see Configuration)

## Operation

- All outputs are 0 in reset. pclk toggles every clk after reset and starts low.
- A tick is a clk edge on which pclk goes 1->0. vsync, href, px_data and state change only on ticks, so they are stable at every pclk rising edge.
- Line length L = 2*H_ACTIVE + H_BLANK pclk periods.
- States:
  - IDLE: all bus outputs low. If run is high at a tick, go to VSYNC and latch pat_sel.
  - VSYNC: vsync high for VSYNC_LINES*L ticks.
  - VBACK: V_BACK*L ticks.
  - ACTIVE: V_ACTIVE lines. Each line has href high for 2*H_ACTIVE ticks, then href low for H_BLANK ticks.
  - VFRONT: V_FRONT*L ticks. On the last tick, pulse frame_done, increment frame_cnt, and latch checksum. Then go to VSYNC if run is high, otherwise IDLE.
- run going low mid-frame does not truncate the frame; it is checked only at the end of VFRONT.
- pat_sel and solid_rgb565 changes take effect only at the next frame start.
- Byte order per pixel P = {R5,G6,B5}: first byte P[15:8], second byte P[7:0]. px_data is 0 whenever href is low.
- Patterns (x = 0..H_ACTIVE-1, y = 0..V_ACTIVE-1):
  - 0, colour bars: bar = x/(H_ACTIVE/8). Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1, gradient: R = x[7:3], G = 0, B = y[6:2].
  - 2, pixel counter: P = (y*H_ACTIVE + x) mod 2^16.
  - 3, solid: P = solid_rgb565.
- Reset asserted mid-operation: outputs go low immediately, state returns to IDLE, counters clear.

## Timing

- With run already high, vsync rises at most 2 clk after reset release or after entry to IDLE.
- Total frame = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT)*L pclk periods. With defaults: 150*464 = 69600 pclk = 139200 clk.
- Alignment: the first href rise follows the vsync fall by exactly V_BACK*L pclk. Each href-high run is exactly 2*H_ACTIVE pclk.
- frame_done is high for exactly one clk, on the tick ending VFRONT. frame_cnt and checksum update on that same edge.

## Configuration

- CAMEMU_CHECKSUM_EN defined:
  - A 16-bit accumulator adds every px_data byte transmitted with href high, mod 2^16.
  - The accumulator clears at vsync rise.
  - Its value is copied to checksum at frame end.
- Not defined: checksum is tied to 0 and no accumulator is synthesised.

## Test plan

- Reset: hold rst=0 with run=1 for 10 clk -> all outputs 0. Release -> vsync rises within 2 clk and pclk toggles every clk.
- Colour bars with defaults: first line bytes 0..39 alternate FF,FF. Bytes 40..41 are FF,E0. Bytes 318..319 are 00,00. Sample at pclk rise: 320 bytes with href high, then 144 pclk with href low.
- Frame timing: count pclk rises while vsync is high -> 1392. From vsync fall to the first href rise -> 7888. Number of href pulses per frame -> 120. frame_done spacing -> 139200 clk.
- Pixel counter mode: the last two active bytes of the frame are 4A, FF. The first two are 00, 00.
- run dropped at line 50 of ACTIVE: the frame completes, frame_done pulses once, the block enters IDLE with vsync staying low, and frame_cnt = 1.
- With CAMEMU_CHECKSUM_EN, solid mode at F800 -> checksum = 0xA800. Without the macro, checksum stays 0.

Source files
------------

// File: rtl/cam_emu_tx.sv
// Synthetic OV7670-style parallel bus source: pclk/vsync/href/px_data with test patterns.
// Optional frame byte checksum enabled by defining CAMEMU_CHECKSUM_EN.
module cam_emu_tx #(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [1:0]  pat_sel,
  input  logic [15:0] solid_rgb565,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  px_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [15:0] checksum
);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  localparam int          L        = 2 * H_ACTIVE + H_BLANK;
  localparam logic [15:0] COL_LAST = 16'(L - 1);
  localparam logic [15:0] HREF_LEN = 16'(2 * H_ACTIVE);
  localparam logic [15:0] BAR_W    = 16'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);

  state_t      state_q, state_d;
  logic        pclk_q;
  logic [15:0] col_q, col_d, line_q, line_d, pix_q, pix_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] solid_q, solid_d;
  logic        vsync_q, vsync_d, href_q, href_d;
  logic [7:0]  px_q, px_d;
  logic        done_q, done_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic        tick, end_line, end_phase, frame_start;
  logic [15:0] last_line, x, pixel;
  logic [2:0]  bar_idx;

  // pclk is high on the edge where it falls, so that edge is the tick.
  assign tick = pclk_q;

  always_comb begin
    last_line = '0;
    case (state_q)
      S_VSYNC:  last_line = 16'(VSYNC_LINES - 1);
      S_VBACK:  last_line = 16'(V_BACK - 1);
      S_ACTIVE: last_line = 16'(V_ACTIVE - 1);
      S_VFRONT: last_line = 16'(V_FRONT - 1);
      default:  last_line = '0;
    endcase
  end

  assign end_line  = (col_q == COL_LAST);
  assign end_phase = end_line && (line_q == last_line);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    line_d      = line_q;
    pix_d       = pix_q;
    pat_d       = pat_q;
    solid_d     = solid_q;
    fcnt_d      = fcnt_q;
    done_d      = 1'b0;
    frame_start = 1'b0;
    if (tick) begin
      if (state_q == S_IDLE) begin
        frame_start = run;
      end else begin
        col_d = end_line ? 16'd0 : col_q + 16'd1;
        if (end_line) line_d = line_q + 16'd1;
        // Advance the pixel index once the second byte of a pixel has gone out.
        if (href_q && col_q[0]) pix_d = pix_q + 16'd1;
        if (end_phase) begin
          line_d = '0;
          case (state_q)
            S_VSYNC:  state_d = S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFRONT;
            default: begin
              done_d      = 1'b1;
              fcnt_d      = fcnt_q + 16'd1;
              state_d     = S_IDLE;
              frame_start = run;
            end
          endcase
        end
      end
      if (frame_start) begin
        state_d = S_VSYNC;
        col_d   = '0;
        line_d  = '0;
        pix_d   = '0;
        pat_d   = pat_sel;
        solid_d = solid_rgb565;
      end
    end
  end

  // Bus values are built from next-state counters so they register on the same tick.
  assign x       = {1'b0, col_d[15:1]};
  assign bar_idx = 3'(x / BAR_W);

  always_comb begin
    pixel = '0;
    case (pat_q)
      2'd0: begin
        case (bar_idx)
          3'd0:    pixel = 16'hFFFF;
          3'd1:    pixel = 16'hFFE0;
          3'd2:    pixel = 16'h07FF;
          3'd3:    pixel = 16'h07E0;
          3'd4:    pixel = 16'hF81F;
          3'd5:    pixel = 16'hF800;
          3'd6:    pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = {x[7:3], 6'd0, line_d[6:2]};
      2'd2:    pixel = pix_d;
      default: pixel = solid_q;
    endcase
  end

  assign vsync_d = (state_d == S_VSYNC);
  assign href_d  = (state_d == S_ACTIVE) && (col_d < HREF_LEN);
  assign px_d    = href_d ? (col_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pclk_q  <= 1'b0;
      col_q   <= '0;
      line_q  <= '0;
      pix_q   <= '0;
      pat_q   <= '0;
      solid_q <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      px_q    <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pclk_q  <= ~pclk_q;
      col_q   <= col_d;
      line_q  <= line_d;
      pix_q   <= pix_d;
      pat_q   <= pat_d;
      solid_q <= solid_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      px_q    <= px_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef CAMEMU_CHECKSUM_EN
  logic [15:0] acc_q, acc_d, acc_sum, cks_q, cks_d;

  always_comb begin
    acc_sum = acc_q;
    if (tick && href_q) acc_sum = acc_q + {8'h00, px_q};
    acc_d = frame_start ? 16'd0 : acc_sum;
    cks_d = done_d ? acc_sum : cks_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      cks_q <= '0;
    end else begin
      acc_q <= acc_d;
      cks_q <= cks_d;
    end
  end

  assign checksum = cks_q;
`else
  assign checksum = 16'h0000;
`endif

  assign pclk       = pclk_q;
  assign vsync      = vsync_q;
  assign href       = href_q;
  assign px_data    = px_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_cam_emu_tx.sv
// Directed bench for cam_emu_tx using a reduced geometry so whole frames fit the run.
module tb_cam_emu_tx;
  localparam int HA = 16, VA = 4, HB = 6, VS = 2, VB = 2, VF = 1;
  localparam int L = 2 * HA + HB;                 // 38 pclk per line
  localparam int FRAME = (VS + VB + VA + VF) * L; // 342 pclk per frame
`ifdef CAMEMU_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, run;
  logic [1:0]  pat_sel;
  logic [15:0] solid_rgb565;
  logic        pclk, vsync, href, frame_done;
  logic [7:0]  px_data;
  logic [15:0] frame_cnt, checksum;

  cam_emu_tx #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
               .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)) dut (
    .clk(clk), .rst(rst), .run(run), .pat_sel(pat_sel), .solid_rgb565(solid_rgb565),
    .pclk(pclk), .vsync(vsync), .href(href), .px_data(px_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .checksum(checksum));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_times[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done === 1'b1) begin
    done_cnt <= done_cnt + 1;
    done_times.push_back(cyc);
  end

  // Per-frame measurements filled by capture_frame.
  logic [7:0] hbytes[$];
  int vs_high, href_pulses, bad_runs, blank_nz, vfall_to_href, hblank_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next pclk rising edge.
  task automatic pstep();
    @(posedge clk); #1;
    if (pclk !== 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic release_and_check();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("pclk_first_rise", pclk, 1);
    check("vsync_low_1clk", vsync, 0);
    @(posedge clk); #1;
    check("pclk_toggle", pclk, 0);
    check("vsync_rise_2clk", vsync, 1);
  endtask

  task automatic capture_frame(input int drop_at, input int chg_at,
                               input logic [1:0] new_pat, input logic [15:0] new_solid);
    logic prev_h, prev_v;
    int run_len, first_vfall, first_hrise, first_hfall, second_hrise;
    hbytes.delete();
    vs_high = 0; href_pulses = 0; bad_runs = 0; blank_nz = 0;
    prev_h = 1'b0; prev_v = 1'b0; run_len = 0;
    first_vfall = -1; first_hrise = -1; first_hfall = -1; second_hrise = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (i == drop_at) run = 1'b0;
      if (i == chg_at) begin
        pat_sel = new_pat;
        solid_rgb565 = new_solid;
      end
      pstep();
      if (vsync) vs_high++;
      if (prev_v && !vsync && first_vfall < 0) first_vfall = i;
      if (href && !prev_h) begin
        href_pulses++;
        run_len = 0;
        if (first_hrise < 0) first_hrise = i;
        else if (second_hrise < 0) second_hrise = i;
      end
      if (!href && prev_h) begin
        if (run_len != 2 * HA) bad_runs++;
        if (first_hfall < 0) first_hfall = i;
      end
      if (href) begin
        run_len++;
        hbytes.push_back(px_data);
      end else if (px_data != 8'h00) begin
        blank_nz++;
      end
      prev_h = href;
      prev_v = vsync;
    end
    vfall_to_href = first_hrise - first_vfall;
    hblank_len = second_hrise - first_hfall;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 8 && done_cnt < target; k++) @(posedge clk);
    #1;
    check("frame_done_count", done_cnt, target);
  endtask

  initial begin
    int vs_seen, solid_bad;
    rst = 1'b0; run = 1'b1; pat_sel = 2'd0; solid_rgb565 = 16'h0000;
    repeat (10) @(negedge clk);
    check("rst_pclk", pclk, 0);
    check("rst_vsync", vsync, 0);
    check("rst_href", href, 0);
    check("rst_px", px_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_cks", checksum, 0);
    release_and_check();

    // Frame 1: colour bars; pat_sel changes mid-frame must not affect it.
    capture_frame(-1, 10, 2'd2, 16'hF800);
    check("f1_vsync_len", vs_high, VS * L);
    check("f1_vfall_href", vfall_to_href, VB * L);
    check("f1_href_pulses", href_pulses, VA);
    check("f1_bad_runs", bad_runs, 0);
    check("f1_hblank", hblank_len, HB);
    check("f1_blank_px", blank_nz, 0);
    check("f1_nbytes", hbytes.size(), 2 * HA * VA);
    check("bar_b0", hbytes[0], 8'hFF);
    check("bar_b3", hbytes[3], 8'hFF);
    check("bar_b4", hbytes[4], 8'hFF);
    check("bar_b5", hbytes[5], 8'hE0);
    check("bar_b8", hbytes[8], 8'h07);
    check("bar_b9", hbytes[9], 8'hFF);
    check("bar_b27", hbytes[27], 8'h1F);
    check("bar_b30", hbytes[30], 8'h00);
    check("bar_b31", hbytes[31], 8'h00);
    check("bar_line1_b5", hbytes[37], 8'hE0);

    // Frame 2: pixel counter.
    capture_frame(-1, 10, 2'd3, 16'hF800);
    check("f2_done", done_cnt, 1);
    check("f2_fcnt", frame_cnt, 1);
    check("f1_checksum", checksum, CKS ? 16'h3FC0 : 16'h0000);
    check("cnt_b0", hbytes[0], 8'h00);
    check("cnt_b1", hbytes[1], 8'h00);
    check("cnt_b3", hbytes[3], 8'h01);
    check("cnt_b32", hbytes[32], 8'h00);
    check("cnt_b33", hbytes[33], 8'h10);
    check("cnt_b126", hbytes[126], 8'h00);
    check("cnt_b127", hbytes[127], 8'h3F);

    // Frame 3: solid F800; solid/pat changes mid-frame wait for the next frame.
    capture_frame(-1, 200, 2'd1, 16'h1234);
    check("f3_fcnt", frame_cnt, 2);
    check("f2_checksum", checksum, CKS ? 16'h07E0 : 16'h0000);
    check("f3_nbytes", hbytes.size(), 2 * HA * VA);
    solid_bad = 0;
    for (int i = 0; i < hbytes.size(); i++)
      if (hbytes[i] !== ((i % 2 == 0) ? 8'hF8 : 8'h00)) solid_bad++;
    check("solid_bytes", solid_bad, 0);
    check("done_spacing", done_times[1] - done_times[0], 2 * FRAME);

    // Frame 4: gradient, run dropped during active line 2.
    capture_frame((VS + VB + 2) * L + 2, -1, 2'd1, 16'h1234);
    check("f3_checksum", checksum, CKS ? 16'h3E00 : 16'h0000);
    check("f4_href_pulses", href_pulses, VA);
    check("grad_b15", hbytes[15], 8'h00);
    check("grad_b16", hbytes[16], 8'h08);
    check("grad_b17", hbytes[17], 8'h00);
    check("grad_b30", hbytes[30], 8'h08);
    wait_done(4);
    check("f4_fcnt", frame_cnt, 4);
    check("f4_checksum", checksum, CKS ? 16'h0100 : 16'h0000);
    vs_seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (vsync !== 1'b0) vs_seen++;
    end
    check("idle_vsync_low", vs_seen, 0);
    check("idle_done_count", done_cnt, 4);

    // Restart, then reset mid-frame.
    run = 1'b1;
    repeat (20) @(negedge clk);
    check("restart_vsync", vsync, 1);
    rst = 1'b0;
    #1;
    check("midrst_vsync", vsync, 0);
    check("midrst_pclk", pclk, 0);
    check("midrst_fcnt", frame_cnt, 0);
    check("midrst_cks", checksum, 0);
    repeat (3) @(negedge clk);
    release_and_check();
    capture_frame((VS + VB + 2) * L + 2, -1, 2'd1, 16'h1234);
    check("rr_href_pulses", href_pulses, VA);
    wait_done(5);
    check("rr_fcnt", frame_cnt, 1);
    vs_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (vsync !== 1'b0) vs_seen++;
    end
    check("rr_idle_vsync", vs_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
